// File: rtl/imm_gen_pipe_pkg.sv
// Shared immediate format codes and the single-lane expansion function
// used by the decode-stage immediate generator.
package imm_gen_pipe_pkg;

   typedef enum logic [4:0] {
      IMM_I  = 5'd0,
      IMM_S  = 5'd1,
      IMM_B  = 5'd2,
      IMM_J  = 5'd3,
      IMM_U  = 5'd4,
      IMM_Z  = 5'd5,
      IMM_SH = 5'd6
   } imm_fmt_e;

   // Operates on instruction bits [31:7] only; the opcode field never
   // contributes to an immediate, so it is not carried through the pipe.
   function automatic logic [31:0] expand_imm(input logic [31:7] inst,
                                              input logic [4:0]  sel);
      logic s;
      s = inst[31];
      case (sel)
         IMM_I:   return {{20{s}}, inst[31:20]};
         IMM_S:   return {{20{s}}, inst[31:25], inst[11:7]};
         IMM_B:   return {{20{s}}, inst[7], inst[30:25], inst[11:8], 1'b0};
         IMM_J:   return {{12{s}}, inst[19:12], inst[20], inst[30:21], 1'b0};
         IMM_U:   return {inst[31:12], 12'b0};
         IMM_Z:   return {27'b0, inst[19:15]};
         IMM_SH:  return {27'b0, inst[24:20]};
         default: return 32'b0;
      endcase
   endfunction

endpackage

// File: rtl/imm_gen_pipe_lane.sv
// Purely combinational single-lane immediate expander with lane enable.
module imm_expand_lane
   import imm_gen_pipe_pkg::*;
(
   input  logic [24:0] inst,
   input  logic [4:0]  sel,
   input  logic        en,
   output logic [31:0] imm
);

   assign imm = en ? expand_imm(inst, sel) : 32'b0;

endmodule

// File: rtl/imm_gen_pipe.sv
// Multi-lane pipelined immediate generator with a two-entry skid buffer,
// flush and a saturating back-pressure counter.
module imm_gen_pipe
   import imm_gen_pipe_pkg::*;
#(
   parameter int LANES = 2,
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [LANES*25-1:0]   in_inst,
   input  logic [LANES*5-1:0]    in_sel,
   input  logic [LANES-1:0]      in_lane_en,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [LANES*XLEN-1:0] out_imm,
   output logic [LANES-1:0]      out_lane_en,
   output logic [CNT_W-1:0]      stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [LANES*XLEN-1:0] new_imm;
   logic                  or_valid;
   logic                  sr_valid;
   logic [LANES*XLEN-1:0] or_imm;
   logic [LANES*XLEN-1:0] sr_imm;
   logic [LANES-1:0]      or_en;
   logic [LANES-1:0]      sr_en;
   logic                  accept;
   logic                  or_free;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      imm_expand_lane u_lane (
         .inst (in_inst[25*k +: 25]),
         .sel  (in_sel[5*k +: 5]),
         .en   (in_lane_en[k]),
         .imm  (new_imm[XLEN*k +: XLEN])
      );
   end

   // in_ready depends only on the skid register, never on out_ready.
   assign in_ready    = !sr_valid;
   assign accept      = in_valid && in_ready;
   assign or_free     = !or_valid || out_ready;
   assign out_valid   = or_valid;
   assign out_imm     = or_imm;
   assign out_lane_en = or_en;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         or_valid  <= 1'b0;
         sr_valid  <= 1'b0;
         or_imm    <= '0;
         sr_imm    <= '0;
         or_en     <= '0;
         sr_en     <= '0;
         stall_cnt <= '0;
      end else begin
         if (or_valid && !out_ready && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if (flush) begin
            or_valid <= 1'b0;
            sr_valid <= 1'b0;
         end else if (or_free) begin
            // A held skid entry always wins the output slot to keep order.
            if (sr_valid) begin
               or_imm   <= sr_imm;
               or_en    <= sr_en;
               or_valid <= 1'b1;
               sr_valid <= 1'b0;
            end else if (accept) begin
               or_imm   <= new_imm;
               or_en    <= in_lane_en;
               or_valid <= 1'b1;
            end else begin
               or_valid <= 1'b0;
            end
         end else if (accept) begin
            sr_imm   <= new_imm;
            sr_en    <= in_lane_en;
            sr_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: format vectors, hand-written
// back-pressure/flush/reset/saturation sequences and a random scoreboard run.
module tb_imm_gen_pipe;
   import imm_gen_pipe_pkg::*;

   localparam int LANES = 2;
   localparam int XLEN  = 32;
   localparam int CNT_W = 4;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  flush = 1'b0;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic [LANES*25-1:0]   in_inst = '0;
   logic [LANES*5-1:0]    in_sel = '0;
   logic [LANES-1:0]      in_lane_en = '0;
   logic                  out_valid;
   logic                  out_ready = 1'b1;
   logic [LANES*XLEN-1:0] out_imm;
   logic [LANES-1:0]      out_lane_en;
   logic [CNT_W-1:0]      stall_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] w0, w1;
      logic [4:0]  s0, s1;
      logic [1:0]  en;
      logic [31:0] e0, e1;
      logic [1:0]  een;
   } vec_t;

   typedef struct {
      logic [31:0] i0, i1;
      logic [1:0]  en;
   } beat_t;

   vec_t  vecs[6];
   beat_t sb[$];
   int    mcnt;

   imm_gen_pipe #(.LANES(LANES), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_inst     (in_inst),
      .in_sel      (in_sel),
      .in_lane_en  (in_lane_en),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_imm     (out_imm),
      .out_lane_en (out_lane_en),
      .stall_cnt   (stall_cnt)
   );

   always #5 clk = ~clk;

   // Reference expansion from plain shift/mask arithmetic on the full word.
   function automatic logic [31:0] ref_imm(input logic [31:0] w, input logic [4:0] sel,
                                           input logic en);
      logic [31:0] sx;
      logic [31:0] ar;
      sx = w[31] ? 32'hFFFFFFFF : 32'h0;
      ar = $signed(w) >>> 20;
      if (!en) return 32'h0;
      case (sel)
         IMM_I:   return ar;
         IMM_S:   return (ar & ~32'h1F) | ((w >> 7) & 32'h1F);
         IMM_B:   return (sx & 32'hFFFFF000) | (((w >> 7) & 1) << 11)
                         | (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1);
         IMM_J:   return (sx & 32'hFFF00000) | (((w >> 12) & 255) << 12)
                         | (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1);
         IMM_U:   return w & 32'hFFFFF000;
         IMM_Z:   return (w >> 15) & 32'h1F;
         IMM_SH:  return (w >> 20) & 32'h1F;
         default: return 32'h0;
      endcase
   endfunction

   function automatic beat_t exp_beat(input logic [31:0] w0, input logic [31:0] w1,
                                      input logic [4:0] s0, input logic [4:0] s1,
                                      input logic [1:0] en);
      beat_t b;
      b.i0 = ref_imm(w0, s0, en[0]);
      b.i1 = ref_imm(w1, s1, en[1]);
      b.en = en;
      return b;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] w0, input logic [31:0] w1,
                                input logic [4:0] s0, input logic [4:0] s1,
                                input logic [1:0] en, input logic valid);
      in_inst    = {w1[31:7], w0[31:7]};
      in_sel     = {s1, s0};
      in_lane_en = en;
      in_valid   = valid;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic checkBeat(input string name, input beat_t b);
      checkOutput({name, "_valid"}, out_valid, 1'b1);
      checkOutput({name, "_imm0"}, out_imm[31:0], b.i0);
      checkOutput({name, "_imm1"}, out_imm[63:32], b.i1);
      checkOutput({name, "_en"}, out_lane_en, b.en);
   endtask

   task automatic doReset();
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      rst_n = 1'b1;
      mcnt  = 0;
      sb.delete();
   endtask

   // Scoreboard for one random cycle, evaluated before the edge.
   task automatic scoreCycle();
      logic rdy;
      checkOutput("rand_out_valid", out_valid, sb.size() != 0);
      checkOutput("rand_in_ready", in_ready, sb.size() < 2);
      rdy = sb.size() < 2;
      if (sb.size() != 0 && !out_ready && mcnt != 15) mcnt++;
      if (flush) begin
         sb.delete();
      end else begin
         if (sb.size() != 0 && out_ready) begin
            checkBeat("rand_beat", sb[0]);
            void'(sb.pop_front());
         end
         if (in_valid && rdy) begin
            sb.push_back(exp_beat({in_inst[49:25], 7'b0}, {in_inst[24:0], 7'b0}
                                  >> 0 == 0 ? 32'h0 : {in_inst[24:0], 7'b0},
                                  in_sel[4:0], in_sel[9:5], in_lane_en));
            sb[$] = exp_beat({in_inst[24:0], 7'b0}, {in_inst[49:25], 7'b0},
                             in_sel[4:0], in_sel[9:5], in_lane_en);
         end
      end
   endtask

   initial begin
      beat_t a, b, c;

      vecs[0] = '{32'h80000000, 32'h12345000, IMM_I, IMM_U, 2'b11,
                  32'hFFFFF800, 32'h12345000, 2'b11};
      vecs[1] = '{32'h80000000, 32'h00000080, IMM_J, IMM_B, 2'b11,
                  32'hFFF00000, 32'h00000800, 2'b11};
      vecs[2] = '{32'hFE000E00, 32'h000F8000, IMM_S, IMM_Z, 2'b11,
                  32'hFFFFFFFC, 32'h0000001F, 2'b11};
      vecs[3] = '{32'h80000000, 32'hFFF00000, IMM_I, IMM_I, 2'b01,
                  32'hFFFFF800, 32'h00000000, 2'b01};
      vecs[4] = '{32'hFFFFFFFF, 32'h01F00000, 5'h1F, IMM_SH, 2'b11,
                  32'h00000000, 32'h0000001F, 2'b11};
      vecs[5] = '{32'hFFFFF123, 32'h00000F80, IMM_U, IMM_S, 2'b10,
                  32'h00000000, 32'h0000001F, 2'b10};

      // Reset state
      doReset();
      checkOutput("reset_out_valid", out_valid, 1'b0);
      checkOutput("reset_in_ready", in_ready, 1'b1);
      checkOutput("reset_stall_cnt", stall_cnt, 0);
      checkOutput("reset_imm", out_imm[31:0], 32'h0);

      // Format table, one beat per cycle with out_ready high
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].w0, vecs[i].w1, vecs[i].s0, vecs[i].s1, vecs[i].en, 1'b1);
         step();
         checkBeat($sformatf("vec%0d", i), '{vecs[i].e0, vecs[i].e1, vecs[i].een});
      end
      in_valid = 1'b0;
      step();
      checkOutput("vec_drain_valid", out_valid, 1'b0);

      // Back-pressure: A to OR, B to SR, C refused until released
      a = exp_beat(32'h80000000, 32'hABCDE000, IMM_I, IMM_U, 2'b11);
      b = exp_beat(32'h00000080, 32'h000F8000, IMM_B, IMM_Z, 2'b11);
      c = exp_beat(32'h01F00000, 32'hFE000E00, IMM_SH, IMM_S, 2'b11);
      doReset();
      out_ready = 1'b0;
      applyStimulus(32'h80000000, 32'hABCDE000, IMM_I, IMM_U, 2'b11, 1'b1);
      step();
      checkBeat("bp_a_loaded", a);
      checkOutput("bp_ready_a", in_ready, 1'b1);
      applyStimulus(32'h00000080, 32'h000F8000, IMM_B, IMM_Z, 2'b11, 1'b1);
      step();
      checkBeat("bp_a_held1", a);
      checkOutput("bp_ready_b", in_ready, 1'b0);
      checkOutput("bp_cnt1", stall_cnt, 1);
      applyStimulus(32'h01F00000, 32'hFE000E00, IMM_SH, IMM_S, 2'b11, 1'b1);
      step();
      checkBeat("bp_a_held2", a);
      checkOutput("bp_ready_c", in_ready, 1'b0);
      out_ready = 1'b1;
      step();
      checkBeat("bp_b_out", b);
      checkOutput("bp_ready_after_move", in_ready, 1'b1);
      step();
      checkBeat("bp_c_out", c);
      in_valid = 1'b0;
      step();
      checkOutput("bp_no_dup", out_valid, 1'b0);
      checkOutput("bp_stall_cnt", stall_cnt, 2);

      // Flush with both entries full and a valid input in the same cycle
      doReset();
      out_ready = 1'b0;
      applyStimulus(32'h80000000, 32'hABCDE000, IMM_I, IMM_U, 2'b11, 1'b1);
      step();
      applyStimulus(32'h00000080, 32'h000F8000, IMM_B, IMM_Z, 2'b11, 1'b1);
      step();
      applyStimulus(32'h01F00000, 32'hFE000E00, IMM_SH, IMM_S, 2'b11, 1'b1);
      flush = 1'b1;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      checkOutput("flush_out_valid", out_valid, 1'b0);
      checkOutput("flush_in_ready", in_ready, 1'b1);
      checkOutput("flush_stall_cnt", stall_cnt, 2);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checkOutput("flush_no_ghost", out_valid, 1'b0);
      end

      // Reset in the middle of a stall
      doReset();
      out_ready = 1'b0;
      applyStimulus(32'h80000000, 32'hABCDE000, IMM_I, IMM_U, 2'b11, 1'b1);
      step();
      applyStimulus(32'h00000080, 32'h000F8000, IMM_B, IMM_Z, 2'b11, 1'b1);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      checkOutput("rst_pre_cnt", stall_cnt, 5);
      rst_n = 1'b0;
      flush = 1'b1;
      step();
      rst_n = 1'b1;
      flush = 1'b0;
      checkOutput("rst_out_valid", out_valid, 1'b0);
      checkOutput("rst_imm0", out_imm[31:0], 32'h0);
      checkOutput("rst_imm1", out_imm[63:32], 32'h0);
      checkOutput("rst_lane_en", out_lane_en, 2'b00);
      checkOutput("rst_stall_cnt", stall_cnt, 0);
      checkOutput("rst_in_ready", in_ready, 1'b1);
      out_ready = 1'b1;
      step();
      checkOutput("rst_no_sr_leak", out_valid, 1'b0);

      // Saturation of the 4-bit stall counter
      doReset();
      out_ready = 1'b0;
      applyStimulus(32'h80000000, 32'hABCDE000, IMM_I, IMM_U, 2'b11, 1'b1);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) step();
      checkOutput("sat_cnt10", stall_cnt, 10);
      for (int i = 0; i < 10; i++) step();
      checkOutput("sat_cnt15", stall_cnt, 15);
      checkBeat("sat_out_held", a);

      // Random traffic against the scoreboard
      doReset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         logic [4:0] s0, s1;
         s0 = ($urandom_range(0, 15) == 0) ? 5'h1F : 5'($urandom_range(0, 6));
         s1 = ($urandom_range(0, 15) == 0) ? 5'h1F : 5'($urandom_range(0, 6));
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         if (flush) out_ready = 1'b0;
         applyStimulus($urandom, $urandom, s0, s1, 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)));
         scoreCycle();
         step();
      end
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         scoreCycle();
         step();
      end
      checkOutput("rand_final_empty", out_valid, 1'b0);
      checkOutput("rand_stall_cnt", stall_cnt, mcnt);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
